// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and constants for the multiply-accumulate sequencer
package mac_pkg;

    // Operand width of the multiplier datapath.
    localparam int OP_W      = 4;
    // Product width of one OP_W x OP_W multiply.
    localparam int PROD_W    = 2 * OP_W;
    // Default length-field width: jobs of 1..8 beats.
    localparam int LEN_W_DEF = 3;
    // Default accumulator width. PROD_W + LEN_W bits hold 2**LEN_W maximal
    // products, so the accumulator cannot wrap.
    localparam int ACC_W_DEF = PROD_W + LEN_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_state_t;

endpackage

// File: rtl/mac_mul4x4.sv
// rtl/mac_mul4x4.sv - combinational 4x4 unsigned multiplier
//
// Ports:
//   a, b : OP_W-bit unsigned operands
//   p    : PROD_W-bit unsigned product a*b
module mac_mul4x4
    import mac_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - framed, length-controlled multiply-accumulate sequencer
//
// Ports:
//   clk, rst_n           : clock; asynchronous active-low reset
//   start, len           : job request (IDLE only); len = beats minus one
//   busy                 : high whenever the FSM is not in IDLE
//   in_valid, in_ready   : operand beat handshake (in_ready only in ACCUM)
//   a, b                 : unsigned operands of one beat
//   res_valid, res_ready : result handshake (res_valid only in DONE)
//   res                  : dot-product result, held until the next start
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res
);

    mac_state_t         state_q;
    mac_state_t         state_d;
    logic [LEN_W-1:0]   cnt_q;
    logic [PROD_W-1:0]  p_q;
    logic               p_vld;
    logic [ACC_W-1:0]   acc_q;
    logic [PROD_W-1:0]  prod;
    logic               fire;
    logic               take_start;

    mac_mul4x4 u_mul (
        .a (a),
        .b (b),
        .p (prod)
    );

    assign busy       = (state_q != IDLE);
    assign in_ready   = (state_q == ACCUM);
    assign res_valid  = (state_q == DONE);
    assign res        = acc_q;
    assign fire       = in_valid && in_ready;
    assign take_start = (state_q == IDLE) && start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (fire && (cnt_q == '0)) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The product register is one stage ahead of the accumulator: a beat
    // accepted at one edge is summed at the next. DRAIN exists only to give
    // the final beat that extra edge before the result is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            p_q   <= '0;
            p_vld <= 1'b0;
            acc_q <= '0;
        end else begin
            p_vld <= fire;
            if (fire) begin
                p_q <= prod;
            end

            // acc is left untouched outside a job so res stays stable
            // through DONE and IDLE until the next honoured start.
            if (take_start) begin
                acc_q <= '0;
            end else if (p_vld) begin
                acc_q <= acc_q + ACC_W'(p_q);
            end

            // The counter only moves on accepted beats, so in_valid gaps hold it.
            if (take_start) begin
                cnt_q <= len;
            end else if (fire && (cnt_q != '0)) begin
                cnt_q <= cnt_q - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - self-checking bench for mac_seq_ctrl
module tb_mac_seq_ctrl;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic [2:0]  len       = '0;
    logic        in_valid  = 1'b0;
    logic [3:0]  a         = '0;
    logic [3:0]  b         = '0;
    logic        res_ready = 1'b0;
    logic        busy;
    logic        in_ready;
    logic        res_valid;
    logic [10:0] res;

    int n_checks = 0;
    int n_fail   = 0;

    mac_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res       (res)
    );

    always #5 clk = ~clk;

    // One job: beat k uses nibble k of a_bits/b_bits; gap_len idle cycles
    // follow beat number gap_after (0 = no gap).
    typedef struct {
        logic [2:0]  len;
        logic [31:0] a_bits;
        logic [31:0] b_bits;
        int          gap_after;
        int          gap_len;
        logic [10:0] exp_res;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE. in_valid is also raised with junk operands
    // to show that a beat coinciding with start is not taken.
    task automatic do_start(input logic [2:0] l);
        start    = 1'b1;
        len      = l;
        in_valid = 1'b1;
        a        = 4'hF;
        b        = 4'hF;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("in_ready_after_start", 32'(in_ready), 32'd1);
    endtask

    task automatic beat(input logic [3:0] av, input logic [3:0] bv);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic handshake(input logic [10:0] exp);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_after_hs", 32'(res_valid), 32'd0);
        chk("busy_after_hs", 32'(busy), 32'd0);
        chk("res_held_in_idle", 32'(res), 32'(exp));
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        chk("idle_busy", 32'(busy), 32'd0);
        do_start(v.len);
        for (int k = 0; k <= int'(v.len); k++) begin
            beat(v.a_bits[4*k +: 4], v.b_bits[4*k +: 4]);
            if (k + 1 == v.gap_after) begin
                for (int g = 0; g < v.gap_len; g++) begin
                    a = 4'hF;
                    b = 4'hF;
                    @(negedge clk);
                    chk("gap_in_ready", 32'(in_ready), 32'd1);
                end
            end
        end
        // Last beat accepted at edge T: DRAIN during T+1, DONE from T+2.
        chk("drain_res_valid", 32'(res_valid), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("done_res_valid", 32'(res_valid), 32'd1);
        chk($sformatf("vec%0d_res", idx), 32'(res), 32'(v.exp_res));
        handshake(v.exp_res);
    endtask

    initial begin
        vecs[0] = '{len: 3'd0, a_bits: 32'h0000_000F, b_bits: 32'h0000_000F,
                    gap_after: 0, gap_len: 0, exp_res: 11'd225};
        vecs[1] = '{len: 3'd3, a_bits: 32'h0000_7531, b_bits: 32'h0000_8642,
                    gap_after: 0, gap_len: 0, exp_res: 11'd100};
        vecs[2] = '{len: 3'd7, a_bits: 32'hFFFF_FFFF, b_bits: 32'hFFFF_FFFF,
                    gap_after: 4, gap_len: 3, exp_res: 11'd1800};
        vecs[3] = '{len: 3'd2, a_bits: 32'h0000_0190, b_bits: 32'h0000_0109,
                    gap_after: 1, gap_len: 1, exp_res: 11'd1};
        vecs[4] = '{len: 3'd7, a_bits: 32'h8765_4321, b_bits: 32'h1111_1111,
                    gap_after: 0, gap_len: 0, exp_res: 11'd36};

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res", 32'(res), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vec(i);
        end

        // Result backpressure; res_ready held high through ACCUM and DRAIN.
        res_ready = 1'b1;
        do_start(3'd1);
        beat(4'd3, 4'd3);
        beat(4'd2, 4'd2);
        chk("bp_drain_res_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        res_ready = 1'b0;
        chk("bp_done_res_valid", 32'(res_valid), 32'd1);
        chk("bp_res", 32'(res), 32'd13);
        for (int k = 0; k < 5; k++) begin
            start = (k % 2 == 0);
            len   = 3'd0;
            @(negedge clk);
            chk("bp_hold_res_valid", 32'(res_valid), 32'd1);
            chk("bp_hold_res", 32'(res), 32'd13);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        start = 1'b0;
        handshake(11'd13);
        do_start(3'd0);
        chk("bp_acc_cleared", 32'(res), 32'd0);
        beat(4'd1, 4'd1);
        @(negedge clk);
        chk("bp_next_res_valid", 32'(res_valid), 32'd1);
        chk("bp_next_res", 32'(res), 32'd1);
        handshake(11'd1);

        // Reset in the middle of an eight-beat job.
        do_start(3'd7);
        beat(4'hF, 4'hF);
        beat(4'hF, 4'hF);
        beat(4'hF, 4'hF);
        chk("mid_job_acc", 32'(res), 32'd450);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        chk("async_rst_res_valid", 32'(res_valid), 32'd0);
        chk("async_rst_res", 32'(res), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(3'd1);
        beat(4'd2, 4'd3);
        beat(4'd4, 4'd5);
        chk("post_rst_drain", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("post_rst_res_valid", 32'(res_valid), 32'd1);
        chk("post_rst_res", 32'(res), 32'd26);
        handshake(11'd26);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for the 4x4 multiply-accumulate datapath. It accepts a programmable-length stream of 4-bit operand pairs over a valid/ready handshake and multiplies each pair through a registered product stage. It accumulates the products into a non-overflowing accumulator and returns the dot product over a second valid/ready handshake. It sits between the pin-level I/O wrapper and the multiplier, replacing free-running accumulation with framed, length-controlled jobs.

## Interface
- LEN_W, 3: width of the length field; job length = len+1 beats (1..8).
- ACC_W, 8+LEN_W (11): accumulator/result width; must be at least 8+LEN_W so the accumulator cannot overflow.
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  single-cycle job request; honoured only in IDLE.
- len  in  LEN_W  beats minus one; sampled when start is honoured.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  high only in ACCUM.
- a, b  in  4 each  unsigned operands.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res  out  ACC_W  dot-product result.

## Operation
- States:
  - IDLE: start moves to ACCUM, clears the accumulator and loads the beat counter with len.
  - ACCUM: each in_valid&&in_ready registers a*b into the product register (p_q, p_vld=1). The beat that fires with counter==0 moves to DRAIN; otherwise the counter decrements.
  - DRAIN: the final product is added; moves to DONE.
  - DONE: res_valid=1. res_valid&&res_ready moves to IDLE.
- Product stage: p_q = a*b, 8 bits unsigned. On every cycle with p_vld=1, acc <= acc + zero-extended p_q. p_vld is cleared when no beat fires.
- res is driven from acc. It is held stable from DONE entry until the next honoured start, including through IDLE.
- Arithmetic: unsigned only. The maximum value (8×225 = 1800) fits in 11 bits, so there is no saturation logic.
- start outside IDLE is ignored and has no latched side effect.
- start and in_valid together in IDLE: the beat is not accepted, because in_ready is 0 that cycle.
- in_valid gaps in ACCUM are allowed, and the counter holds during gaps.
- a, b and in_valid are don't-care when in_ready is 0.
- Reset mid-job: the job is abandoned. All registers clear and the FSM returns to IDLE.

## Timing
- Reset values: busy=0, in_ready=0, res_valid=0, res=0, acc=0, p_vld=0, state=IDLE.
- start accepted at edge T: busy=1 and in_ready=1 from T+1.
- Throughput: one beat per cycle while in_valid is held.
- Latency: last beat accepted at edge T, then DRAIN during cycle T+1, then res_valid=1 from T+2.
- The minimum job, len=0, takes start at edge T0, the beat at T0+1, and res_valid at T0+3.
- res_valid&&res_ready at edge T: res_valid=0 and busy=0 from T+1. A new start is honoured at edge T+1 at the earliest.
- res_ready asserted before DONE has no effect.

## Structure
- Shared package mac_pkg holds:
  - the state enum (IDLE, ACCUM, DRAIN, DONE);
  - the LEN_W and ACC_W defaults;
  - the operand width constant, 4.
- One sub-module, mac_mul4x4: a combinational 4x4 unsigned multiplier producing an 8-bit product, instantiated once feeding p_q.
- FSM, beat counter, product register and accumulator live in mac_seq_ctrl.

## Test plan
- Single beat: reset, start with len=0, then beat a=15, b=15 → res=225 and res_valid exactly 2 cycles after the beat.
- Four beats: len=3, beats (1,2), (3,4), (5,6), (7,8) back-to-back → res=100.
- Full length, maximum values: len=7, eight beats of (15,15) with in_valid dropped for 3 cycles after beat 4 → res=1800 and no overflow.
- Result backpressure: hold res_ready=0 for 5 cycles in DONE while pulsing start → res_valid stays high, res stays stable and start is ignored. The first job after the handshake starts from acc=0.
- Reset mid-job: len=7, deassert rst_n after 3 beats → all outputs go to 0 immediately (asynchronously). A new job len=1 with beats (2,3), (4,5) → res=26.
